serial_cmp_ctrl: RTL and testbench
==================================

Name: serial_cmp_ctrl

Overview:
- Sequencer for a single one-bit magnitude-compare slice. The slice takes equal-in `e0`, greater-in `g0` and operand bits `a1` and `b1`, and produces `e1 = e0 & (a1 ~^ b1)` and `g1 = g0 | (e0 & b1 & ~a1)`.
- The block latches two WIDTH-bit operands and feeds them MSB-first, one bit per clock, through the slice, keeping the running equal/greater state in registers.
- It reports `eq` (a==b) and `b_gt_a` (b>a) with a start/busy/done handshake.
- It replaces a WIDTH-deep cascade of slices when area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only when busy=0.
- a  input  WIDTH  operand A; sampled in the start cycle only.
- b  input  WIDTH  operand B; sampled in the start cycle only.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when results are valid.
- eq  output  1  registered result: a==b.
- b_gt_a  output  1  registered result: b>a.

Behaviour:
- Reset: when rst=1 at an edge:
  - state→IDLE; busy=0, done=0, eq=0, b_gt_a=0.
  - Shift registers, counter, e_reg and g_reg cleared.
  - Reset wins over start. Reset mid-compare aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Load sh_a←a, sh_b←b, e_reg←1, g_reg←0, cnt←WIDTH-1.
  - Go to RUN.
- IDLE or DONE with start=0:
  - Go to (or stay in) IDLE.
- RUN, every cycle:
  - Slice inputs: a1=sh_a[MSB], b1=sh_b[MSB], e0=e_reg, g0=g_reg.
  - e_reg←e1, g_reg←g1.
  - sh_a and sh_b shift left by one, zero fill.
  - If cnt==0: eq←e1, b_gt_a←g1, go to DONE. Otherwise cnt←cnt-1.
  - start is ignored in RUN; operands are not re-sampled.
- DONE: done=1 for exactly this one cycle, then IDLE unless start is accepted.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state.
- Latency: start sampled at edge of cycle N.
  - busy=1 in cycles N+1..N+WIDTH.
  - done=1, with eq/b_gt_a valid, in cycle N+WIDTH+1.
  - Back-to-back: start high in the done cycle begins the next compare with no idle gap.
- Result hold: eq and b_gt_a change only at the completion edge or at reset. They hold through IDLE and through later RUN phases until overwritten.
- Invariant: eq and b_gt_a are never both 1. a>b is encoded as eq=0, b_gt_a=0.
- cnt width = $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - In RUN, if e1==0 (first differing bit found), latch eq←0, b_gt_a←g1 and go to DONE immediately, regardless of cnt.
  - Latency = (index from MSB of the first differing bit)+1 RUN cycles. Equal operands still take WIDTH cycles.
- Undefined: fixed WIDTH-cycle latency as above; the result is identical in both builds.

Decomposition:
- Package serial_cmp_pkg:
  - State enum cmp_state_t {IDLE, RUN, DONE}, 2-bit encoding.
  - Localparam helper for counter width.
- Sub-module cmp_bit_slice: purely combinational one-bit slice with ports a1, b1, e0, g0 → e1, g1. Instantiated once in serial_cmp_ctrl.
- The FSM, shift registers and counter stay in the top module.

Test Plan (WIDTH=8):
- Reset: assert rst 2 cycles while start=1 → busy=0, done=0, eq=0, b_gt_a=0; no compare starts.
- Equal operands: a=0xA5, b=0xA5, start 1 cycle → busy high 8 cycles; done in cycle N+9 with eq=1, b_gt_a=0. Same latency with SERIAL_CMP_EARLY_EXIT_EN.
- Greater/less:
  - a=0x3C, b=0x7C → eq=0, b_gt_a=1.
  - a=0x80, b=0x7F → eq=0, b_gt_a=0.
  - With SERIAL_CMP_EARLY_EXIT_EN: first case done at N+3, second at N+2. Without it: both at N+9.
- Start during busy: second start with different operands at cycle N+4 → ignored; result reflects the first operands. Back-to-back start in the done cycle → new busy begins next cycle; done pulses exactly once per compare.
- Mid-operation reset: rst at cycle N+5 → no done pulse; outputs zero; a subsequent compare with a=0x01, b=0x02 completes normally with b_gt_a=1.
- Randomised sweep: 1000 random a/b pairs against the reference a==b and b>a; eq and b_gt_a are never both 1.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and counter sizing.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cmp_state_t;

    // Bit-index counter must be at least one bit wide even for WIDTH=2.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/cmp_bit_slice.sv
// One-bit magnitude-compare slice: propagates running equal and b-greater flags.
module cmp_bit_slice (
    input  logic a1,
    input  logic b1,
    input  logic e0,
    input  logic g0,
    output logic e1,
    output logic g1
);

    always_comb begin
        e1 = e0 & (a1 ~^ b1);
        g1 = g0 | (e0 & b1 & ~a1);
    end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial MSB-first comparator sequencer around a single cmp_bit_slice.
// Optional SERIAL_CMP_EARLY_EXIT_EN finishes as soon as the first differing bit is seen.
module serial_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             b_gt_a
);

    localparam int unsigned CW = cnt_width(WIDTH);

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             g_q, g_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             e1, g1;
    logic             last;

    cmp_bit_slice u_slice (
        .a1 (sh_a_q[WIDTH-1]),
        .b1 (sh_b_q[WIDTH-1]),
        .e0 (e_q),
        .g0 (g_q),
        .e1 (e1),
        .g1 (g1)
    );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign last = (cnt_q == '0) || !e1;
`else
    assign last = (cnt_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        g_d     = g_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            RUN: begin
                e_d    = e1;
                g_d    = g1;
                sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
                sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
                if (last) begin
                    eq_d    = e1;
                    gt_d    = g1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    e_d     = 1'b1;
                    g_d     = 1'b0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            g_q     <= g_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign eq     = eq_q;
    assign b_gt_a = gt_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed and random checks for serial_cmp_ctrl at WIDTH=8, in either SERIAL_CMP_EARLY_EXIT_EN build.
module tb_serial_cmp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       eq;
    logic       b_gt_a;

    int checks = 0;
    int errors = 0;
    logic m_eq = 1'b0;
    logic m_gt = 1'b0;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam int L_3C7C = 2;
    localparam int L_807F = 1;
`else
    localparam int L_3C7C = 8;
    localparam int L_807F = 8;
`endif

    serial_cmp_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .eq     (eq),
        .b_gt_a (b_gt_a)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [7:0] av, input logic [7:0] bv);
        int l = 8;
        for (int i = 0; i < 8; i++)
            if (av[i] != bv[i]) l = 8 - i;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return l;
`else
        return (l > 0) ? 8 : 8;
`endif
    endfunction

    // Leaves the bench in the done cycle; inject_at>0 fires a stray start in that busy cycle.
    task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic exp_eq, input logic exp_gt, input int exp_n,
                           input int inject_at);
        int n = 0;
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            check({tag, "_hold_eq"}, 32'(eq), 32'(m_eq));
            check({tag, "_hold_gt"}, 32'(b_gt_a), 32'(m_gt));
            if (n == inject_at) begin
                a = 8'h00;
                b = 8'hFF;
                start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_eq"}, 32'(eq), 32'(exp_eq));
        check({tag, "_gt"}, 32'(b_gt_a), 32'(exp_gt));
        check({tag, "_excl"}, 32'(eq & b_gt_a), 32'd0);
        m_eq = exp_eq;
        m_gt = exp_gt;
    endtask

    initial begin
        int done_seen;
        logic [7:0] ra, rb;

        rst = 1'b1;
        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_eq", 32'(eq), 32'd0);
        check("rst_gt", 32'(b_gt_a), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        step();
        check("rst_nostart", 32'(busy), 32'd0);

        run_cmp("eqA5", 8'hA5, 8'hA5, 1'b1, 1'b0, 8, 0);
        step();
        check("eqA5_pulse", 32'(done), 32'd0);
        step();
        check("idle_hold_eq", 32'(eq), 32'd1);

        run_cmp("lt3C", 8'h3C, 8'h7C, 1'b0, 1'b1, L_3C7C, 0);
        step();
        run_cmp("gt80", 8'h80, 8'h7F, 1'b0, 1'b0, L_807F, 0);
        step();

        run_cmp("inject", 8'h13, 8'h12, 1'b0, 1'b0, 8, 4);
        step();
        check("inject_idle", 32'(busy), 32'd0);

        run_cmp("b2b1", 8'h3C, 8'h7C, 1'b0, 1'b1, L_3C7C, 0);
        run_cmp("b2b2", 8'hA5, 8'hA5, 1'b1, 1'b0, 8, 0);
        run_cmp("b2b3", 8'h3C, 8'h7C, 1'b0, 1'b1, L_3C7C, 0);
        step();
        check("b2b_pulse", 32'(done), 32'd0);

        a = 8'h13;
        b = 8'h12;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_eq = 1'b0;
        m_gt = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_eq", 32'(eq), 32'd0);
        check("mrst_gt", 32'(b_gt_a), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        check("mrst_nodone", 32'(done_seen), 32'd0);
        run_cmp("post_rst", 8'h01, 8'h02, 1'b0, 1'b1, exp_lat(8'h01, 8'h02), 0);
        step();

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = (i % 8 == 0) ? ra : 8'($urandom);
            run_cmp("rnd", ra, rb, ra == rb, rb > ra, exp_lat(ra, rb), 0);
            if ($urandom_range(1) == 0) step();
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
